// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared constants and helpers for the switch debouncer
package sw_debounce_pkg;
  localparam int SYNC_STAGES = 2;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: single-bit synchroniser, stability counter, clean level and edge strobes
module debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic upd_o
);
  localparam int CW = cnt_w(STABLE_CYCLES);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic clean_q, clean_d, rise_q, fall_q;
  logic sync2, differ;
  assign sync2 = sync_q[SYNC_STAGES-1];
  assign differ = sync2 ^ clean_q;
  assign upd_o = differ && (cnt_q == CW'(STABLE_CYCLES - 1));
  assign clean_o = clean_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  // any matching sample or a completed update restarts the stability count
  always_comb begin
    cnt_d = (!differ || upd_o) ? '0 : cnt_q + 1'b1;
    clean_d = upd_o ? sync2 : clean_q;
  end
  // synchroniser, counter, clean level and one-cycle strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      clean_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q <= cnt_d;
      clean_q <= clean_d;
      rise_q <= upd_o & sync2;
      fall_q <= upd_o & ~sync2;
    end
  end
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit switch debouncer with edge strobes and a combined change pulse
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic changed
);
  logic [WIDTH-1:0] upd;
  logic changed_q;
  assign changed = changed_q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_ch #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch (
      .clk(clk),
      .rst(rst),
      .raw_i(sw_raw[i]),
      .clean_o(sw_clean[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i]),
      .upd_o(upd[i])
    );
  end
  // change pulse registered on the same edge as the per-bit strobes
  always_ff @(posedge clk) begin
    if (rst) changed_q <= 1'b0;
    else changed_q <= |upd;
  end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed table-driven and sequence checks for sw_debounce
module tb_sw_debounce;
  localparam int W = 9;
  localparam int SC = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_clean, rise, fall;
  logic changed;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic r;
    logic [W-1:0] raw;
    logic [W-1:0] clean;
    logic [W-1:0] rs;
    logic [W-1:0] fl;
    logic ch;
  } vec_t;
  vec_t tbl[$];

  sw_debounce #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .sw_clean(sw_clean),
    .rise(rise),
    .fall(fall),
    .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic add(input int n, input logic r, input logic [W-1:0] raw, input logic [W-1:0] c,
                     input logic [W-1:0] rs, input logic [W-1:0] fl, input logic ch);
    for (int i = 0; i < n; i++) tbl.push_back('{r, raw, c, rs, fl, ch});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] c, input logic [W-1:0] rs,
                     input logic [W-1:0] fl, input logic ch);
    checks++;
    if (sw_clean !== c || rise !== rs || fall !== fl || changed !== ch) begin
      failures++;
      $display("FAIL %s: got clean=%h rise=%h fall=%h changed=%b, want clean=%h rise=%h fall=%h changed=%b",
               nm, sw_clean, rise, fall, changed, c, rs, fl, ch);
    end
  endtask

  initial begin
    int nrise;
    int bp[5];
    bp = '{1, 0, 1, 0, 1};
    add(3, 1'b1, 9'h1FF, 9'h000, 9'h000, 9'h000, 1'b0);
    add(5, 1'b0, 9'h1FF, 9'h000, 9'h000, 9'h000, 1'b0);
    add(1, 1'b0, 9'h1FF, 9'h1FF, 9'h1FF, 9'h000, 1'b1);
    add(1, 1'b0, 9'h1FF, 9'h1FF, 9'h000, 9'h000, 1'b0);
    add(2, 1'b1, 9'h000, 9'h000, 9'h000, 9'h000, 1'b0);
    add(5, 1'b0, 9'h008, 9'h000, 9'h000, 9'h000, 1'b0);
    add(1, 1'b0, 9'h008, 9'h008, 9'h008, 9'h000, 1'b1);
    add(1, 1'b0, 9'h008, 9'h008, 9'h000, 9'h000, 1'b0);
    add(5, 1'b0, 9'h000, 9'h008, 9'h000, 9'h000, 1'b0);
    add(1, 1'b0, 9'h000, 9'h000, 9'h000, 9'h008, 1'b1);
    add(1, 1'b0, 9'h000, 9'h000, 9'h000, 9'h000, 1'b0);
    foreach (tbl[i]) begin
      rst = tbl[i].r;
      sw_raw = tbl[i].raw;
      tick();
      chk($sformatf("table[%0d]", i), tbl[i].clean, tbl[i].rs, tbl[i].fl, tbl[i].ch);
    end

    nrise = 0;
    for (int k = 1; k <= 12; k++) begin
      sw_raw[0] = (k <= 5) ? bp[k-1][0] : 1'b1;
      tick();
      nrise += int'(rise[0]);
      chk($sformatf("bounce[%0d]", k), (k >= 10) ? 9'h001 : 9'h000,
          (k == 10) ? 9'h001 : 9'h000, 9'h000, k == 10);
    end
    checks++;
    if (nrise != 1) begin
      failures++;
      $display("FAIL bounce_count: got %0d rise pulses, want 1", nrise);
    end

    for (int k = 1; k <= 10; k++) begin
      sw_raw[5] = (k <= 3);
      tick();
      chk($sformatf("glitch[%0d]", k), 9'h001, 9'h000, 9'h000, 1'b0);
    end

    sw_raw = 9'h003;
    repeat (8) tick();
    chk("simul_setup", 9'h003, 9'h000, 9'h000, 1'b0);
    sw_raw = 9'h101;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("simul[%0d]", k), (k >= 6) ? 9'h101 : 9'h003,
          (k == 6) ? 9'h100 : 9'h000, (k == 6) ? 9'h002 : 9'h000, k == 6);
    end

    sw_raw = 9'h105;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("rstmid_pre[%0d]", k), 9'h101, 9'h000, 9'h000, 1'b0);
    end
    rst = 1'b1;
    tick();
    chk("rstmid_rst", 9'h000, 9'h000, 9'h000, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("rstmid_post[%0d]", k), (k >= 6) ? 9'h105 : 9'h000,
          (k == 6) ? 9'h105 : 9'h000, 9'h000, k == 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
